// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - control sequencer for the shared multiply/divide datapath
//
// Runs radix-4 Booth multiplication (MULT_ITERS steps) or restoring division
// (DIV_ITERS steps plus a sign fix-up) and ends with a one-cycle ready pulse.
// A start seen while busy aborts the current operation and reloads.
// Optional feature macro: MULTDIV_OVF_EN (report multiply overflow as an exception).
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   ctrl_MULT, ctrl_DIV     start requests (multiply has priority)
//   booth_bits              product[1:0] plus appended bit, Booth window
//   rem_neg                 trial remainder sign after the current subtract
//   divisor_zero, sign_diff operand status, valid during LOAD
//   prod_ovf                multiply overflow status, valid during DONE
//   load                    latch operands, clear accumulators
//   add, sub, nop           Booth action for this iteration
//   shiftMultiplicand       use 2x multiplicand for add/sub
//   shiftProduct            arithmetic shift product right by 2
//   div_step, div_restore   divide shift/trial-subtract and restore
//   negate                  negate the quotient
//   is_div                  result mux select
//   busy                    operation in progress
//   data_resultRDY          one-cycle completion pulse
//   data_exception          exception flag, valid with data_resultRDY
module multdiv_sequencer #(
   parameter int WIDTH      = 32,
   parameter int MULT_ITERS = WIDTH / 2,
   parameter int DIV_ITERS  = WIDTH
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ctrl_MULT,
   input  logic       ctrl_DIV,
   input  logic [2:0] booth_bits,
   input  logic       rem_neg,
   input  logic       divisor_zero,
   input  logic       sign_diff,
   input  logic       prod_ovf,
   output logic       load,
   output logic       add,
   output logic       sub,
   output logic       shiftMultiplicand,
   output logic       shiftProduct,
   output logic       nop,
   output logic       div_step,
   output logic       div_restore,
   output logic       negate,
   output logic       is_div,
   output logic       busy,
   output logic       data_resultRDY,
   output logic       data_exception
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

   state_t     state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic       op_div_q, op_div_d;
   logic       neg_q, neg_d;
   logic       exc_q, exc_d;
   logic       load_q, load_d;
   logic       shift_product_q, shift_product_d;
   logic       div_step_q, div_step_d;
   logic       negate_q, negate_d;
   logic       is_div_q, is_div_d;
   logic       busy_q, busy_d;
   logic       rdy_q, rdy_d;
   logic       ovf_exc;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_div_d = op_div_q;
      neg_d    = neg_q;
      exc_d    = exc_q;
      case (state_q)
         S_IDLE: begin
            if (ctrl_MULT || ctrl_DIV) begin
               state_d  = S_LOAD;
               op_div_d = ~ctrl_MULT;
            end
         end
         S_LOAD: begin
            neg_d = sign_diff;
            cnt_d = 6'd0;
            if (op_div_q && divisor_zero) begin
               state_d = S_DONE;
               exc_d   = 1'b1;
            end else begin
               state_d = op_div_q ? S_DIV : S_MULT;
               exc_d   = 1'b0;
            end
         end
         S_MULT: begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(MULT_ITERS - 1)) state_d = S_DONE;
         end
         S_DIV: begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(DIV_ITERS - 1)) state_d = S_FIX;
         end
         S_FIX:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // A start while busy (including DONE) restarts with the same priority.
      if (state_q != S_IDLE && (ctrl_MULT || ctrl_DIV)) begin
         state_d  = S_LOAD;
         op_div_d = ~ctrl_MULT;
         cnt_d    = 6'd0;
         exc_d    = 1'b0;
      end
      // Moore outputs are registered from the next state.
      load_d          = (state_d == S_LOAD);
      shift_product_d = (state_d == S_MULT);
      div_step_d      = (state_d == S_DIV);
      negate_d        = (state_d == S_FIX) && neg_d;
      busy_d          = (state_d != S_IDLE);
      rdy_d           = (state_d == S_DONE);
      is_div_d        = op_div_d && (state_d != S_IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         cnt_q           <= 6'd0;
         op_div_q        <= 1'b0;
         neg_q           <= 1'b0;
         exc_q           <= 1'b0;
         load_q          <= 1'b0;
         shift_product_q <= 1'b0;
         div_step_q      <= 1'b0;
         negate_q        <= 1'b0;
         is_div_q        <= 1'b0;
         busy_q          <= 1'b0;
         rdy_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         op_div_q        <= op_div_d;
         neg_q           <= neg_d;
         exc_q           <= exc_d;
         load_q          <= load_d;
         shift_product_q <= shift_product_d;
         div_step_q      <= div_step_d;
         negate_q        <= negate_d;
         is_div_q        <= is_div_d;
         busy_q          <= busy_d;
         rdy_q           <= rdy_d;
      end
   end

   // Booth window decode and restore select follow the datapath inputs within
   // the same cycle, so they are gated by the current state only.
   always_comb begin
      add               = 1'b0;
      sub               = 1'b0;
      shiftMultiplicand = 1'b0;
      nop               = 1'b0;
      if (state_q == S_MULT) begin
         case (booth_bits)
            3'b001, 3'b010: add = 1'b1;
            3'b011: begin
               add               = 1'b1;
               shiftMultiplicand = 1'b1;
            end
            3'b100: begin
               sub               = 1'b1;
               shiftMultiplicand = 1'b1;
            end
            3'b101, 3'b110: sub = 1'b1;
            default:        nop = 1'b1;
         endcase
      end
   end

`ifdef MULTDIV_OVF_EN
   assign ovf_exc = ~op_div_q & prod_ovf;
`else
   logic unused_prod_ovf;
   assign unused_prod_ovf = prod_ovf;
   assign ovf_exc         = 1'b0;
`endif

   assign div_restore    = (state_q == S_DIV) && rem_neg;
   assign load           = load_q;
   assign shiftProduct   = shift_product_q;
   assign div_step       = div_step_q;
   assign negate         = negate_q;
   assign is_div         = is_div_q;
   assign busy           = busy_q;
   assign data_resultRDY = rdy_q;
   // prod_ovf is only valid in DONE, so the flag is formed in that cycle.
   assign data_exception = rdy_q && (exc_q || ovf_exc);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - directed and randomized checks of multdiv_sequencer
module tb_multdiv_sequencer;

   localparam int WIDTH = 32;
   localparam int MI    = WIDTH / 2;
   localparam int DI    = WIDTH;
`ifdef MULTDIV_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       ctrl_MULT, ctrl_DIV;
   logic [2:0] booth_bits;
   logic       rem_neg, divisor_zero, sign_diff, prod_ovf;
   logic       load, add, sub, shiftMultiplicand, shiftProduct, nop;
   logic       div_step, div_restore, negate, is_div, busy;
   logic       data_resultRDY, data_exception;
   logic [12:0] obs;

   int total = 0;
   int bad   = 0;

   multdiv_sequencer #(.WIDTH(WIDTH)) dut (
      .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
      .booth_bits(booth_bits), .rem_neg(rem_neg), .divisor_zero(divisor_zero),
      .sign_diff(sign_diff), .prod_ovf(prod_ovf), .load(load), .add(add), .sub(sub),
      .shiftMultiplicand(shiftMultiplicand), .shiftProduct(shiftProduct), .nop(nop),
      .div_step(div_step), .div_restore(div_restore), .negate(negate), .is_div(is_div),
      .busy(busy), .data_resultRDY(data_resultRDY), .data_exception(data_exception)
   );

   always #5 clock = ~clock;

   assign obs = {load, add, sub, shiftMultiplicand, shiftProduct, nop,
                 div_step, div_restore, negate, is_div, busy, data_resultRDY, data_exception};

   task automatic chk(input string tag, input logic [12:0] o, input logic [12:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic logic [12:0] ev(input bit ld, input bit ad, input bit sb, input bit sm,
                                      input bit sp, input bit np, input bit ds, input bit dr,
                                      input bit ng, input bit isd, input bit bsy,
                                      input bit rdy, input bit exc);
      return {ld, ad, sb, sm, sp, np, ds, dr, ng, isd, bsy, rdy, exc};
   endfunction

   // Booth radix-4 digit value of the window: -2*b2 + b1 + b0.
   function automatic logic [12:0] mult_ev(input logic [2:0] b);
      int d;
      d = int'(b[1]) + int'(b[0]) - 2 * int'(b[2]);
      return ev(0, d > 0, d < 0, (d == 2) || (d == -2), 1, d == 0, 0, 0, 0, 0, 1, 0, 0);
   endfunction

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic run_mult(input bit both, input bit seq_booth, input bit ovf);
      logic [2:0] b;
      ctrl_MULT = 1'b1;
      ctrl_DIV  = both;
      tick();
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      chk("m_load", obs, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      tick();
      for (int i = 0; i < MI; i++) begin
         b = seq_booth ? 3'(i % 8) : 3'($urandom_range(0, 7));
         booth_bits = b;
         #1;
         chk("m_iter", obs, mult_ev(b));
         tick();
      end
      prod_ovf   = ovf;
      booth_bits = 3'($urandom_range(0, 7));
      #1;
      chk("m_done", obs, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, OVF_EN && ovf));
      tick();
      prod_ovf = 1'b0;
      chk("m_idle", obs, 13'd0);
   endtask

   task automatic run_div(input bit sgn, input bit zero, input bit alt);
      bit r;
      ctrl_DIV     = 1'b1;
      sign_diff    = sgn;
      divisor_zero = zero;
      tick();
      ctrl_DIV = 1'b0;
      chk("d_load", obs, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tick();
      sign_diff    = 1'b0;
      divisor_zero = 1'b0;
      if (zero) begin
         chk("dz_done", obs, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
      end else begin
         for (int i = 0; i < DI; i++) begin
            r = alt ? i[0] : 1'($urandom_range(0, 1));
            rem_neg = r;
            #1;
            chk("d_iter", obs, ev(0, 0, 0, 0, 0, 0, 1, r, 0, 1, 1, 0, 0));
            tick();
         end
         chk("d_fix", obs, ev(0, 0, 0, 0, 0, 0, 0, 0, sgn, 1, 1, 0, 0));
         tick();
         chk("d_done", obs, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
      end
      tick();
      chk("d_idle", obs, 13'd0);
   endtask

   initial begin
      reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; booth_bits = 3'd0;
      rem_neg = 1'b0; divisor_zero = 1'b0; sign_diff = 1'b0; prod_ovf = 1'b0;
      tick();
      tick();
      chk("reset_state", obs, 13'd0);
      reset = 1'b0;
      tick();
      chk("idle_state", obs, 13'd0);

      // multiply with booth window walking 000..111
      run_mult(1'b0, 1'b1, 1'b0);
      // randomized multiplies, prod_ovf ignored unless overflow reporting is built in
      for (int k = 0; k < 3; k++) run_mult(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      // divide with alternating rem_neg and differing signs
      run_div(1'b1, 1'b0, 1'b1);
      run_div(1'b0, 1'b0, 1'b0);
      // divide by zero
      run_div(1'b1, 1'b1, 1'b0);
      // both starts high: multiply wins
      run_mult(1'b1, 1'b0, 1'b1);

      // multiply aborted by divide in cycle 8; divide ready in cycle 43
      ctrl_MULT = 1'b1;
      tick();
      ctrl_MULT = 1'b0;
      for (int c = 1; c < 8; c++) begin
         chk("ab_no_rdy", 13'(data_resultRDY), 13'd0);
         tick();
      end
      ctrl_DIV = 1'b1;
      tick();
      ctrl_DIV = 1'b0;
      chk("ab_load", 13'({load, is_div, busy}), 13'b111);
      for (int c = 9; c <= 44; c++) begin
         rem_neg = 1'($urandom_range(0, 1));
         #1;
         chk("ab_rdy", 13'(data_resultRDY), 13'(c == 43));
         tick();
      end
      chk("ab_idle", obs, 13'd0);

      // restart sampled in DONE: ready still pulses, LOAD follows directly
      ctrl_MULT = 1'b1;
      tick();
      ctrl_MULT = 1'b0;
      for (int c = 1; c < MI + 2; c++) tick();
      chk("rs_rdy", 13'({data_resultRDY, busy}), 13'b11);
      ctrl_DIV     = 1'b1;
      divisor_zero = 1'b1;
      tick();
      ctrl_DIV = 1'b0;
      chk("rs_load", obs, ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tick();
      divisor_zero = 1'b0;
      chk("rs_dz", obs, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
      tick();
      chk("rs_idle", obs, 13'd0);

      // reset in cycle 10 of a divide
      ctrl_DIV  = 1'b1;
      sign_diff = 1'b1;
      tick();
      ctrl_DIV = 1'b0;
      for (int c = 1; c < 10; c++) begin
         rem_neg = 1'b1;
         tick();
      end
      chk("rst_pre", 13'({div_step, busy}), 13'b11);
      reset = 1'b1;
      #1;
      chk("rst_now", obs, 13'd0);
      tick();
      reset     = 1'b0;
      sign_diff = 1'b0;
      rem_neg   = 1'b0;
      chk("rst_after", obs, 13'd0);
      run_mult(1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
